sobel_stream_engine: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge engine: raster pixel stream in, edge-strength stream out.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 33 +++
 rtl/sobel_stream_engine.sv | 219 +++++++++++++++++++++
 tb/tb_sobel_stream_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel engine.
//   mode_e  : output-mode encodings driven on mode_i
//   state_e : frame-framing FSM states
//   sat_dw  : clamp a magnitude to the largest dw-bit unsigned value
package sobel_pkg;

   typedef enum logic [1:0] {
      MODE_MAG = 2'd0,
      MODE_THR = 2'd1,
      MODE_GX  = 2'd2,
      MODE_GY  = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   function automatic logic [31:0] sat_dw(input logic [31:0] mag, input int unsigned dw);
      logic [31:0] lim;
      lim = (32'd1 << dw) - 32'd1;
      return (mag > lim) ? lim : mag;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row delay line for the Sobel window.
//   clk    : clock
//   en     : pixel accepted this cycle; storage and outputs change only when set
//   addr   : column of the accepted pixel
//   din    : accepted pixel
//   row1_o : pixel at addr from the previous line (registered)
//   row2_o : pixel at addr from two lines back (registered)
// Synchronous read-before-write, no reset, so it maps onto block RAM.
module sobel_line_buffer #(
   parameter int unsigned DW    = 8,
   parameter int unsigned IMG_W = 640
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(IMG_W)-1:0] addr,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            row1_o,
   output logic [DW-1:0]            row2_o
);

   logic [DW-1:0] mem1 [IMG_W];
   logic [DW-1:0] mem2 [IMG_W];

   always_ff @(posedge clk) begin
      if (en) begin
         row1_o     <= mem1[addr];
         row2_o     <= mem2[addr];
         mem1[addr] <= din;
         mem2[addr] <= mem1[addr];
      end
   end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine with runtime output modes and frame framing.
//   clk, rst      : clock; asynchronous active-low reset
//   pix_i/valid_i : raster pixel stream, no backpressure
//   sof_i         : with valid_i, pixel (0,0) of a new frame
//   mode_i        : 0 |Gx|+|Gy|, 1 threshold, 2 |Gx|, 3 |Gy|
//   thresh_i      : threshold for mode 1
//   pix_o/valid_o : edge value stream, 3 cycles after the accepting edge
//   eol_o         : last output of a line
//   frame_done_o  : last output of the frame
//   err_o         : one-cycle pulse when sof_i arrives mid-frame
module sobel_stream_engine
   import sobel_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] pix_i,
   input  logic          valid_i,
   input  logic          sof_i,
   input  logic [1:0]    mode_i,
   input  logic [DW+2:0] thresh_i,
   output logic [DW-1:0] pix_o,
   output logic          valid_o,
   output logic          eol_o,
   output logic          frame_done_o,
   output logic          err_o
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          accept, err_d;

   // Position of the pixel on the bus; a frame start forces (0,0).
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      accept  = 1'b0;
      err_d   = 1'b0;
      cur_col = sof_i ? '0 : col_q;
      cur_row = sof_i ? '0 : row_q;
      unique case (state_q)
         IDLE: begin
            if (valid_i && sof_i) begin
               accept  = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (valid_i) begin
               accept = 1'b1;
               err_d  = sof_i;
            end
         end
      endcase
      if (accept) begin
         if (cur_col == LAST_COL) begin
            col_d = '0;
            if (cur_row == LAST_ROW) begin
               row_d   = '0;
               state_d = IDLE;
            end else begin
               row_d = cur_row + RW'(1);
            end
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   logic [DW-1:0] row1, row2;

   sobel_line_buffer #(
      .DW    (DW),
      .IMG_W (IMG_W)
   ) u_line_buffer (
      .clk    (clk),
      .en     (accept),
      .addr   (cur_col),
      .din    (pix_i),
      .row1_o (row1),
      .row2_o (row2)
   );

   // Window: left/middle columns in registers, right column is {row2, row1, pix_q}.
   // Index 0 = top row, 2 = bottom row.
   logic [2:0][DW-1:0] win_l_q, win_m_q;
   logic [DW-1:0]      pix_q;

   logic          s0_valid_q, s0_eol_q, s0_fd_q;
   mode_e         s0_mode_q, s1_mode_q, s2_mode_q;
   logic [DW+2:0] s0_thr_q, s1_thr_q, s2_thr_q;
   logic          s1_valid_q, s1_eol_q, s1_fd_q;
   logic [DW+2:0] gxp_q, gxn_q, gyp_q, gyn_q;
   logic          s2_valid_q, s2_eol_q, s2_fd_q;
   logic [DW+1:0] ax_q, ay_q;
   logic [DW+2:0] mag_q;

   logic [DW+2:0] gxp_c, gxn_c, gyp_c, gyn_c, gx_c, gy_c, ax_c, ay_c, mag_c;
   logic [31:0]   sat_v;
   logic [DW-1:0] pix_c;
   logic          unused_sat;

   always_comb begin
      gxp_c = {3'b0, row2} + {2'b0, row1, 1'b0} + {3'b0, pix_q};
      gxn_c = {3'b0, win_l_q[0]} + {2'b0, win_l_q[1], 1'b0} + {3'b0, win_l_q[2]};
      gyp_c = {3'b0, win_l_q[2]} + {2'b0, win_m_q[2], 1'b0} + {3'b0, pix_q};
      gyn_c = {3'b0, win_l_q[0]} + {2'b0, win_m_q[0], 1'b0} + {3'b0, row2};
      // Two's-complement difference; |G| never exceeds DW+2 bits.
      gx_c  = gxp_q - gxn_q;
      gy_c  = gyp_q - gyn_q;
      ax_c  = gx_c[DW+2] ? ({(DW+3){1'b0}} - gx_c) : gx_c;
      ay_c  = gy_c[DW+2] ? ({(DW+3){1'b0}} - gy_c) : gy_c;
      mag_c = ax_c + ay_c;
   end

   always_comb begin
      sat_v = '0;
      unique case (s2_mode_q)
         MODE_MAG: sat_v = sat_dw(32'(mag_q), DW);
         MODE_THR: sat_v = (mag_q >= s2_thr_q) ? sat_dw(32'hffff_ffff, DW) : '0;
         MODE_GX:  sat_v = sat_dw(32'(ax_q), DW);
         MODE_GY:  sat_v = sat_dw(32'(ay_q), DW);
      endcase
      pix_c = sat_v[DW-1:0];
   end
   assign unused_sat = ^sat_v[31:DW];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_l_q      <= '0;
         win_m_q      <= '0;
         pix_q        <= '0;
         s0_valid_q   <= 1'b0;
         s0_eol_q     <= 1'b0;
         s0_fd_q      <= 1'b0;
         s0_mode_q    <= MODE_MAG;
         s0_thr_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_eol_q     <= 1'b0;
         s1_fd_q      <= 1'b0;
         s1_mode_q    <= MODE_MAG;
         s1_thr_q     <= '0;
         gxp_q        <= '0;
         gxn_q        <= '0;
         gyp_q        <= '0;
         gyn_q        <= '0;
         s2_valid_q   <= 1'b0;
         s2_eol_q     <= 1'b0;
         s2_fd_q      <= 1'b0;
         s2_mode_q    <= MODE_MAG;
         s2_thr_q     <= '0;
         ax_q         <= '0;
         ay_q         <= '0;
         mag_q        <= '0;
         pix_o        <= '0;
         valid_o      <= 1'b0;
         eol_o        <= 1'b0;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         if (accept) begin
            win_l_q   <= win_m_q;
            win_m_q   <= {pix_q, row1, row2};
            pix_q     <= pix_i;
            s0_eol_q  <= (cur_col == LAST_COL);
            s0_fd_q   <= (cur_col == LAST_COL) && (cur_row == LAST_ROW);
            s0_mode_q <= mode_e'(mode_i);
            s0_thr_q  <= thresh_i;
         end
         s0_valid_q   <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
         s1_valid_q   <= s0_valid_q;
         s1_eol_q     <= s0_eol_q;
         s1_fd_q      <= s0_fd_q;
         s1_mode_q    <= s0_mode_q;
         s1_thr_q     <= s0_thr_q;
         gxp_q        <= gxp_c;
         gxn_q        <= gxn_c;
         gyp_q        <= gyp_c;
         gyn_q        <= gyn_c;
         s2_valid_q   <= s1_valid_q;
         s2_eol_q     <= s1_eol_q;
         s2_fd_q      <= s1_fd_q;
         s2_mode_q    <= s1_mode_q;
         s2_thr_q     <= s1_thr_q;
         ax_q         <= ax_c[DW+1:0];
         ay_q         <= ay_c[DW+1:0];
         mag_q        <= mag_c;
         valid_o      <= s2_valid_q;
         pix_o        <= s2_valid_q ? pix_c : '0;
         eol_o        <= s2_valid_q && s2_eol_q;
         frame_done_o <= s2_valid_q && s2_fd_q;
         err_o        <= err_d;
      end
   end

endmodule

// File: tb/tb_sobel_stream_engine.sv
module tb_sobel_stream_engine;

   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] pix_i = '0;
   logic          valid_i = 1'b0;
   logic          sof_i = 1'b0;
   logic [1:0]    mode_i = '0;
   logic [DW+2:0] thresh_i = '0;
   logic [DW-1:0] pix_o;
   logic          valid_o, eol_o, frame_done_o, err_o;

   sobel_stream_engine #(
      .DW    (DW),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_i        (pix_i),
      .valid_i      (valid_i),
      .sof_i        (sof_i),
      .mode_i       (mode_i),
      .thresh_i     (thresh_i),
      .pix_o        (pix_o),
      .valid_o      (valid_o),
      .eol_o        (eol_o),
      .frame_done_o (frame_done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int pix;
      bit eol;
      bit fd;
      int due;
   } exp_t;
   exp_t q[$];

   typedef struct {
      int pat;
      int mode;
      int thr;
      int gap;
      int exp_cnt;
      int exp_sum;
   } vec_t;
   vec_t vecs[8];

   int total = 0;
   int bad   = 0;

   // Reference model state: current frame image and raster position.
   int img[H][W];
   bit m_active = 0;
   int m_r = 0, m_c = 0;
   int exp_err = 0;

   int out_cnt = 0, out_sum = 0, eol_cnt = 0, fd_cnt = 0, err_seen = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int clip(int v);
      return (v > 255) ? 255 : v;
   endfunction

   // Output for the window whose bottom-right pixel is (r,c).
   function automatic int ref_val(int r, int c, int mode, int thr);
      int gx, gy, ax, ay, mag;
      gx  = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
          - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy  = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
          - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      mag = ax + ay;
      case (mode)
         0:       return clip(mag);
         1:       return (mag >= thr) ? 255 : 0;
         2:       return clip(ax);
         default: return clip(ay);
      endcase
   endfunction

   task automatic model_accept(input bit s, input int p, input int m, input int t);
      exp_t e;
      if (s) begin
         if (m_active) exp_err++;
         m_active = 1;
         m_r = 0;
         m_c = 0;
      end
      if (m_active) begin
         img[m_r][m_c] = p;
         if (m_r >= 2 && m_c >= 2) begin
            e.pix = ref_val(m_r, m_c, m, t);
            e.eol = ((m_c - 1) == W - 2);
            e.fd  = ((m_c - 1) == W - 2) && ((m_r - 1) == H - 2);
            e.due = cyc + 4;
            q.push_back(e);
         end
         m_c++;
         if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) begin
               m_r = 0;
               m_active = 0;
            end
         end
      end
   endtask

   task automatic observe();
      exp_t e;
      if (err_o) err_seen++;
      if (valid_o) begin
         if (q.size() == 0) begin
            check("unexpected_valid", int'(valid_o), 0);
         end else begin
            e = q.pop_front();
            check("out_pix", int'(pix_o), e.pix);
            check("out_eol", int'(eol_o), int'(e.eol));
            check("out_frame_done", int'(frame_done_o), int'(e.fd));
            check("out_latency", cyc, e.due);
         end
         out_cnt++;
         out_sum += int'(pix_o);
         eol_cnt += int'(eol_o);
         fd_cnt  += int'(frame_done_o);
      end
   endtask

   // One clock: drive after the rising edge, sample on the falling edge.
   task automatic cycle(input bit v, input bit s, input int p, input int m, input int t);
      @(posedge clk);
      #1;
      valid_i  = v;
      sof_i    = s;
      pix_i    = DW'(p);
      mode_i   = 2'(m);
      thresh_i = (DW+3)'(t);
      if (v) model_accept(s, p, m, t);
      @(negedge clk);
      observe();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 0, 0, 0);
   endtask

   function automatic int pixel(int pat, int c);
      case (pat)
         0:       return 100;
         1:       return (c >= 4) ? 255 : 0;
         2:       return (c >= 4) ? 10 : 0;
         default: begin
            if ($urandom_range(0, 3) == 0) return 255;
            return int'($urandom_range(0, 255));
         end
      endcase
   endfunction

   task automatic run_frame(input int pat, input int mode, input int thr, input int gap,
                            input bit sof_en, input bit rnd);
      int m, t, g;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            m = rnd ? int'($urandom_range(0, 3)) : mode;
            t = rnd ? int'($urandom_range(0, 600)) : thr;
            cycle(1, sof_en && r == 0 && c == 0, pixel(pat, c), m, t);
            g = rnd ? int'($urandom_range(0, 3) == 0) : gap;
            repeat (g) cycle(0, 0, 0, m, t);
         end
      end
   endtask

   int b_cnt, b_sum, b_eol, b_fd, b_err;

   task automatic snap();
      b_cnt = out_cnt;
      b_sum = out_sum;
      b_eol = eol_cnt;
      b_fd  = fd_cnt;
      b_err = err_seen;
   endtask

   initial begin
      vecs[0] = '{pat: 0, mode: 0, thr: 0,  gap: 0, exp_cnt: 24, exp_sum: 0};
      vecs[1] = '{pat: 1, mode: 0, thr: 0,  gap: 0, exp_cnt: 24, exp_sum: 2040};
      vecs[2] = '{pat: 1, mode: 3, thr: 0,  gap: 0, exp_cnt: 24, exp_sum: 0};
      vecs[3] = '{pat: 2, mode: 1, thr: 40, gap: 0, exp_cnt: 24, exp_sum: 2040};
      vecs[4] = '{pat: 2, mode: 1, thr: 41, gap: 0, exp_cnt: 24, exp_sum: 0};
      vecs[5] = '{pat: 1, mode: 2, thr: 0,  gap: 0, exp_cnt: 24, exp_sum: 2040};
      vecs[6] = '{pat: 1, mode: 0, thr: 0,  gap: 1, exp_cnt: 24, exp_sum: 2040};
      vecs[7] = '{pat: 2, mode: 0, thr: 0,  gap: 0, exp_cnt: 24, exp_sum: 320};

      #1 rst = 1'b0;
      #3;
      check("rst_valid", int'(valid_o), 0);
      check("rst_pix", int'(pix_o), 0);
      check("rst_eol", int'(eol_o), 0);
      check("rst_frame_done", int'(frame_done_o), 0);
      check("rst_err", int'(err_o), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         snap();
         run_frame(vecs[i].pat, vecs[i].mode, vecs[i].thr, vecs[i].gap, 1, 0);
         idle(6);
         check($sformatf("vec%0d_count", i), out_cnt - b_cnt, vecs[i].exp_cnt);
         check($sformatf("vec%0d_sum", i), out_sum - b_sum, vecs[i].exp_sum);
         check($sformatf("vec%0d_eol", i), eol_cnt - b_eol, 4);
         check($sformatf("vec%0d_frame_done", i), fd_cnt - b_fd, 1);
         check($sformatf("vec%0d_drain", i), q.size(), 0);
      end

      // sof at input pixel 20 restarts the frame and flags an error.
      snap();
      for (int k = 0; k < 20; k++) cycle(1, k == 0, pixel(1, k % W), 0, 0);
      run_frame(1, 0, 0, 0, 1, 0);
      idle(6);
      check("mid_sof_err", err_seen - b_err, 1);
      check("mid_sof_count", out_cnt - b_cnt, 26);
      check("mid_sof_sum", out_sum - b_sum, 2040);
      check("mid_sof_frame_done", fd_cnt - b_fd, 1);

      // Asynchronous reset while outputs are streaming.
      snap();
      for (int k = 0; k < 28; k++) cycle(1, k == 0, pixel(1, k % W), 0, 0);
      check("pre_rst_count", out_cnt - b_cnt, 6);
      check("pre_rst_valid", int'(valid_o), 1);
      #1 rst = 1'b0;
      #1;
      check("async_rst_valid", int'(valid_o), 0);
      check("async_rst_pix", int'(pix_o), 0);
      check("async_rst_eol", int'(eol_o), 0);
      valid_i = 1'b0;
      q.delete();
      m_active = 0;
      m_r = 0;
      m_c = 0;
      idle(2);
      rst = 1'b1;
      snap();
      idle(8);
      check("post_rst_silent", out_cnt - b_cnt, 0);
      run_frame(1, 0, 0, 0, 0, 0);
      idle(6);
      check("no_sof_frame_count", out_cnt - b_cnt, 0);
      snap();
      run_frame(1, 0, 0, 0, 1, 0);
      idle(6);
      check("after_rst_count", out_cnt - b_cnt, 24);
      check("after_rst_sum", out_sum - b_sum, 2040);

      // Random pixels, per-pixel random mode/threshold, random input gaps.
      for (int f = 0; f < 4; f++) begin
         snap();
         run_frame(3, 0, 0, 0, 1, 1);
         idle(6);
         check($sformatf("rand%0d_count", f), out_cnt - b_cnt, 24);
         check($sformatf("rand%0d_frame_done", f), fd_cnt - b_fd, 1);
      end

      check("final_drain", q.size(), 0);
      check("err_total", err_seen, exp_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
